// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage sitting directly behind the register file.
//
// Latches two operands, an opcode and a destination register on start, then
// computes either a single-cycle ALU result or, optionally, a shift-add
// multiply (one multiplier bit per cycle). The result is returned to the
// register file as a one-cycle write-back request.
//
// Build option: define ALU_EXEC_MUL_EN to compile in the MUL state and the
// multiplier datapath. Without it, opcode 4'b1001 is reported as illegal.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only while idle
//   opcode       operation select
//   srcA, srcB   operands (regReadData0 / regReadData1)
//   destSel      destination register for write-back
//   busy         high from the cycle after start is accepted through write-back
//   done         one-cycle pulse in the write-back cycle
//   illegal      one-cycle pulse with done for unsupported opcodes
//   flags        {N,Z,C,V} of the last completed legal op
//   regWriteSel  write-back register select
//   writeEnable  write-back strobe
//   writeData    write-back data

module alu_exec_stage #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SEL_W      = 5,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [SEL_W-1:0] destSel,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [3:0]       flags,
    output logic [SEL_W-1:0] regWriteSel,
    output logic             writeEnable,
    output logic [WIDTH-1:0] writeData
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned MSB     = WIDTH - 1;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpAnd = 4'b0010;
    localparam logic [3:0] OpOr  = 4'b0011;
    localparam logic [3:0] OpXor = 4'b0100;
    localparam logic [3:0] OpSlt = 4'b0101;
    localparam logic [3:0] OpSll = 4'b0110;
    localparam logic [3:0] OpSrl = 4'b0111;
    localparam logic [3:0] OpSra = 4'b1000;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OpMul = 4'b1001;
`endif

    // The shift-add loop retires one multiplier bit per cycle.
    if (MUL_CYCLES != WIDTH) begin : gMulCyclesCheck
        $error("alu_exec_stage: MUL_CYCLES must equal WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
`ifdef ALU_EXEC_MUL_EN
        StMul  = 2'd2,
`endif
        StWb   = 2'd3
    } state_t;

    state_t             stateQ;
    logic [3:0]         opcodeQ;
    logic [WIDTH-1:0]   aQ;        // also the left-shifting multiplicand
    logic [WIDTH-1:0]   bQ;        // also the right-shifting multiplier
    logic [SEL_W-1:0]   destSelQ;

    // Single-cycle ALU
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     subSum;
    logic [WIDTH-1:0]   aluRes;
    logic               aluC;
    logic               aluV;
    logic               aluLegal;
    logic [SHAMT_W-1:0] shamt;

    assign addSum = {1'b0, aQ} + {1'b0, bQ};
    // A + ~B + 1: the carry out is set exactly when A >= B unsigned.
    assign subSum = {1'b0, aQ} + {1'b0, ~bQ} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt  = bQ[SHAMT_W-1:0];

    always_comb begin
        aluRes   = '0;
        aluC     = 1'b0;
        aluV     = 1'b0;
        aluLegal = 1'b1;
        case (opcodeQ)
            OpAdd: begin
                aluRes = addSum[WIDTH-1:0];
                aluC   = addSum[WIDTH];
                aluV   = (aQ[MSB] == bQ[MSB]) && (aluRes[MSB] != aQ[MSB]);
            end
            OpSub: begin
                aluRes = subSum[WIDTH-1:0];
                aluC   = subSum[WIDTH];
                aluV   = (aQ[MSB] != bQ[MSB]) && (aluRes[MSB] != aQ[MSB]);
            end
            OpAnd: aluRes = aQ & bQ;
            OpOr:  aluRes = aQ | bQ;
            OpXor: aluRes = aQ ^ bQ;
            OpSlt: aluRes = {{(WIDTH - 1){1'b0}}, ($signed(aQ) < $signed(bQ))};
            OpSll: aluRes = aQ << shamt;
            OpSrl: aluRes = aQ >> shamt;
            OpSra: aluRes = $signed(aQ) >>> shamt;
            // MUL never reaches write-back through this path when compiled in.
            default: aluLegal = 1'b0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    localparam int unsigned CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MUL_CYCLES - 1);

    logic [WIDTH-1:0] accQ;
    logic [WIDTH-1:0] accNext;
    logic [CNT_W-1:0] cntQ;

    assign accNext = accQ + (bQ[0] ? aQ : '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ      <= StIdle;
            opcodeQ     <= '0;
            aQ          <= '0;
            bQ          <= '0;
            destSelQ    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            flags       <= '0;
            regWriteSel <= '0;
            writeEnable <= 1'b0;
            writeData   <= '0;
`ifdef ALU_EXEC_MUL_EN
            accQ        <= '0;
            cntQ        <= '0;
`endif
        end else begin
            case (stateQ)
                StIdle: begin
                    if (start) begin
                        opcodeQ  <= opcode;
                        aQ       <= srcA;
                        bQ       <= srcB;
                        destSelQ <= destSel;
                        busy     <= 1'b1;
                        stateQ   <= StExec;
                    end
                end
                StExec: begin
`ifdef ALU_EXEC_MUL_EN
                    if (opcodeQ == OpMul) begin
                        accQ   <= '0;
                        cntQ   <= '0;
                        stateQ <= StMul;
                    end else
`endif
                    begin
                        done   <= 1'b1;
                        stateQ <= StWb;
                        if (aluLegal) begin
                            writeEnable <= 1'b1;
                            regWriteSel <= destSelQ;
                            writeData   <= aluRes;
                            flags       <= {aluRes[MSB], (aluRes == '0), aluC, aluV};
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                StMul: begin
                    accQ <= accNext;
                    aQ   <= aQ << 1;
                    bQ   <= bQ >> 1;
                    cntQ <= cntQ + 1'b1;
                    if (cntQ == CntLast) begin
                        done        <= 1'b1;
                        writeEnable <= 1'b1;
                        regWriteSel <= destSelQ;
                        writeData   <= accNext;
                        flags       <= {accNext[MSB], (accNext == '0), 2'b00};
                        stateQ      <= StWb;
                    end
                end
`endif
                StWb: begin
                    done        <= 1'b0;
                    illegal     <= 1'b0;
                    writeEnable <= 1'b0;
                    busy        <= 1'b0;
                    stateQ      <= StIdle;
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage. Expected write-backs are produced by
// a behavioural model when an op is driven, queued, and compared when the DUT
// pulses done. Works for both builds (ALU_EXEC_MUL_EN defined or not).

module tb_alu_exec_stage;

    localparam int W = 32;
    localparam int S = 5;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_ILL = 4'b1111;

`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic [S-1:0] destSel;
    logic         busy;
    logic         done;
    logic         illegal;
    logic [3:0]   flags;
    logic [S-1:0] regWriteSel;
    logic         writeEnable;
    logic [W-1:0] writeData;

    alu_exec_stage #(
        .WIDTH     (W),
        .SEL_W     (S),
        .MUL_CYCLES(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .srcA       (srcA),
        .srcB       (srcB),
        .destSel    (destSel),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .flags      (flags),
        .regWriteSel(regWriteSel),
        .writeEnable(writeEnable),
        .writeData  (writeData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         we;
        logic         ill;
        logic [S-1:0] sel;
        logic [W-1:0] data;
        logic [3:0]   flags;
    } exp_t;

    exp_t         sb[$];
    exp_t         monE;
    logic [3:0]   modelFlags;
    logic [W-1:0] tbRegs [32];
    int           passCnt    = 0;
    int           totalCnt   = 0;
    int           failCnt    = 0;
    int           writesSeen = 0;
    int           writesBase;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference, written independently of the RTL datapath.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [S-1:0] dest);
        exp_t               e;
        longint             sa;
        longint             sbv;
        longint             wide;
        logic [W:0]         s33;
        logic signed [W-1:0] as;
        logic [63:0]        prod;
        logic [W-1:0]       r;
        logic               c;
        logic               v;
        e.we  = 1'b1;
        e.ill = 1'b0;
        e.sel = dest;
        r     = '0;
        c     = 1'b0;
        v     = 1'b0;
        sa    = $signed(a);
        sbv   = $signed(b);
        case (op)
            OP_ADD: begin
                s33  = {1'b0, a} + {1'b0, b};
                r    = s33[W-1:0];
                c    = s33[W];
                wide = sa + sbv;
                v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            OP_SUB: begin
                r    = a - b;
                c    = (a >= b);
                wide = sa - sbv;
                v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLT: r = (sa < sbv) ? 32'd1 : 32'd0;
            OP_SLL: r = a << b[4:0];
            OP_SRL: r = a >> b[4:0];
            OP_SRA: begin
                as = a;
                r  = as >>> b[4:0];
            end
            OP_MUL: begin
                if (MUL_EN) begin
                    prod = {32'b0, a} * {32'b0, b};
                    r    = prod[31:0];
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.we    = 1'b0;
            e.data  = '0;
            e.flags = modelFlags;
        end else begin
            e.data  = r;
            e.flags = {r[W-1], (r == 0), c, v};
        end
        return e;
    endfunction

    function automatic int latFor(input logic [3:0] op);
        return (op == OP_MUL && MUL_EN) ? 34 : 2;
    endfunction

    task automatic pushExp(input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [S-1:0] dest);
        exp_t e;
        e          = model(op, a, b, dest);
        modelFlags = e.flags;
        sb.push_back(e);
    endtask

    // Drive one request; returns 1 time unit after the sampling edge.
    task automatic startOp(input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [S-1:0] dest);
        @(negedge clk);
        opcode  = op;
        srcA    = a;
        srcB    = b;
        destSel = dest;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        // Operands are latched; scrambling the inputs must not matter.
        opcode  = 4'($urandom);
        srcA    = $urandom;
        srcB    = $urandom;
        destSel = 5'($urandom);
        pushExp(op, a, b, dest);
    endtask

    // Latency = cycle (counted from the start edge) in which done is high.
    task automatic waitDone(input string tag, input int expLat);
        int n       = 0;
        int busyCnt = 0;
        if (busy) busyCnt++;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busyCnt++;
        end
        check({tag, " latency"}, 64'(n + 1), 64'(expLat));
        check({tag, " busy cycles"}, 64'(busyCnt), 64'(expLat));
        @(posedge clk);
        #1;
        check({tag, " busy released"}, 64'(busy), 64'd0);
        check({tag, " done one cycle"}, 64'(done), 64'd0);
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [S-1:0] dest);
        startOp(op, a, b, dest);
        waitDone(tag, latFor(op));
    endtask

    // Scoreboard: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("scoreboard has entry at done", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                monE = sb.pop_front();
                check("writeEnable", 64'(writeEnable), 64'(monE.we));
                check("illegal", 64'(illegal), 64'(monE.ill));
                check("flags", 64'(flags), 64'(monE.flags));
                if (monE.we) begin
                    check("regWriteSel", 64'(regWriteSel), 64'(monE.sel));
                    check("writeData", 64'(writeData), 64'(monE.data));
                end
            end
        end
        if (!rst && writeEnable) writesSeen++;
    end

    // Tiny register-file model fed by the write port.
    always @(posedge clk) begin
        if (!rst && writeEnable) tbRegs[regWriteSel] <= writeData;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        opcode     = '0;
        srcA       = '0;
        srcB       = '0;
        destSel    = '0;
        modelFlags = '0;
        for (int i = 0; i < 32; i++) tbRegs[i] = 32'hDEAD_BEEF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset illegal", 64'(illegal), 64'd0);
        check("reset writeEnable", 64'(writeEnable), 64'd0);
        check("reset flags", 64'(flags), 64'd0);
        check("reset regWriteSel", 64'(regWriteSel), 64'd0);
        check("reset writeData", 64'(writeData), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD wrap to zero; r5 then reads 0
        runOp("add wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd5);
        check("add wrap flags NZCV", 64'(flags), 64'b0110);
        check("r5 after add wrap", 64'(tbRegs[5]), 64'd0);

        // SUB signed overflow, then SRA of the most negative value
        runOp("sub ovf", OP_SUB, 32'h8000_0000, 32'd1, 5'd31);
        check("sub ovf flags NZCV", 64'(flags), 64'b0011);
        runOp("sra", OP_SRA, 32'h8000_0000, 32'd4, 5'd7);
        check("r7 after sra", 64'(tbRegs[7]), 64'hF800_0000);

        // Remaining ALU ops, including destSel 0 and shift-amount masking
        runOp("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        check("r0 written", 64'(tbRegs[0]), 64'h00F0_1200);
        runOp("or", OP_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd1);
        runOp("xor", OP_XOR, 32'hAAAA_5555, 32'hAAAA_5555, 5'd2);
        runOp("slt neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd3);
        runOp("slt pos", OP_SLT, 32'd1, 32'hFFFF_FFFF, 5'd4);
        runOp("sll mask", OP_SLL, 32'd1, 32'h25, 5'd6);
        runOp("srl", OP_SRL, 32'h8000_0000, 32'd31, 5'd8);
        runOp("sub borrow", OP_SUB, 32'd1, 32'd2, 5'd9);

        // MUL: 34-cycle multiply when compiled in, 2-cycle illegal otherwise
        runOp("mul", OP_MUL, 32'h0000_FFF0, 32'h0000_0010, 5'd16);
        runOp("mul wide", OP_MUL, 32'hDEAD_BEEF, 32'h1234_5679, 5'd17);
        runOp("opcode 1111", OP_ILL, 32'h1234, 32'h5678, 5'd18);
        check("flags held over illegal", 64'(flags), 64'(modelFlags));

        // A few random ops through the model
        for (int i = 0; i < 6; i++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            runOp("random", rop, $urandom, $urandom, 5'($urandom));
        end

        // start raised during EXEC and held through WB is ignored
        startOp(OP_ADD, 32'd10, 32'd20, 5'd3);
        start   = 1'b1;
        opcode  = OP_XOR;
        destSel = 5'd4;
        @(posedge clk);
        #1;
        check("busy-start: wb done", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy-start: not accepted in WB", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("busy-start: stays idle", 64'(busy), 64'd0);

        // Reset in the middle of an operation
        runOp("pre-reset sub", OP_SUB, 32'h8000_0000, 32'd1, 5'd12);
        startOp(OP_MUL, 32'h0000_FFF0, 32'h0000_0010, 5'd16);
        repeat (MUL_EN ? 10 : 1) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid-op reset busy", 64'(busy), 64'd0);
        check("mid-op reset writeEnable", 64'(writeEnable), 64'd0);
        check("mid-op reset flags", 64'(flags), 64'd0);
        check("mid-op reset done", 64'(done), 64'd0);
        sb.delete();
        modelFlags = '0;
        @(negedge clk);
        rst = 1'b0;
        runOp("post-reset add", OP_ADD, 32'd3, 32'd4, 5'd9);
        check("r9 after post-reset add", 64'(tbRegs[9]), 64'd7);

        // start held high: one accepted ADD every third cycle
        writesBase = writesSeen;
        @(negedge clk);
        opcode  = OP_ADD;
        srcA    = 32'hFFFF_000F;
        srcB    = 32'd0;
        destSel = 5'd0;
        start   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            pushExp(OP_ADD, 32'hFFFF_000F, 32'(i), 5'(i));
            if (i == 15) start = 1'b0;
            @(posedge clk);
            #1;
            check("b2b done in WB", 64'(done), 64'd1);
            @(posedge clk);
            #1;
            check("b2b idle before next", 64'(busy), 64'd0);
            if (i < 15) begin
                srcB    = 32'(i + 1);
                destSel = 5'(i + 1);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        check("b2b write count", 64'(writesSeen - writesBase), 64'd16);
        check("b2b r0", 64'(tbRegs[0]), 64'hFFFF_000F);
        check("b2b r15", 64'(tbRegs[15]), 64'hFFFF_001E);
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of registerFile.
- Takes the two read operands (regReadData0/1) plus an opcode and destination select, and computes the result (single-cycle ALU op or 32-cycle shift-add multiply).
- Drives a one-cycle write-back request (regWriteSel / writeEnable / writeData) into the register file's write port.
- Handshake is start/busy/done.

Parameters:
- WIDTH, 32, operand/result width; must match register file data width.
- SEL_W, 5, register select width (32 registers).
- MUL_CYCLES, 32, multiply iterations; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- opcode  input  4  operation select, encoding below
- srcA  input  WIDTH  operand A (from regReadData0)
- srcB  input  WIDTH  operand B (from regReadData1)
- destSel  input  SEL_W  destination register for write-back
- busy  output  1  high from the cycle after start is accepted until the WB cycle inclusive
- done  output  1  one-cycle pulse in the WB state
- illegal  output  1  one-cycle pulse with done when the opcode is unsupported
- flags  output  4  {N,Z,C,V} of the last completed op; held between ops
- regWriteSel  output  SEL_W  write-back register select
- writeEnable  output  1  write-back strobe, one cycle
- writeData  output  WIDTH  write-back data

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; internal operand/accumulator registers 0; any pending write-back is discarded.
- States: IDLE, EXEC, MUL, WB.
- IDLE: if start=1 at a rising edge, latch opcode/srcA/srcB/destSel and go to EXEC. Operand inputs may change afterwards.
- EXEC: compute the result into the result register.
  - Opcode 1001 (MUL): go to MUL instead.
  - All other opcodes: go to WB.
- Opcodes:
  - 0000 ADD; 0001 SUB (A-B); 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLT: signed compare, result 1 or 0.
  - 0110 SLL, 0111 SRL, 1000 SRA: shift A by B[4:0].
  - 1001 MUL: low WIDTH bits of the unsigned product.
  - 1010-1111: illegal.
- MUL: shift-add, one multiplier bit per cycle, LSB first. Exits to WB after exactly MUL_CYCLES cycles, so it spends 32 cycles in MUL.
- WB: done=1 for one cycle.
  - Legal op: writeEnable=1, regWriteSel=latched destSel, writeData=result, flags updated.
  - Illegal op: writeEnable=0, illegal=1, flags unchanged.
  - Next state is always IDLE.
- Outputs in non-WB states: writeEnable, done and illegal are 0. regWriteSel and writeData hold their last values.
- Latency, counted from the start-sampling edge to done high:
  - Non-MUL ops: 2 cycles (EXEC, then WB).
  - MUL: 34 cycles (EXEC + 32 MUL + WB).
  - Back-to-back throughput for non-MUL ops: one op per 3 cycles, because start is only accepted in IDLE.
- start is ignored while busy, including a start that is high in the WB cycle. It is not queued.
- Flags, computed on the WIDTH-bit result:
  - N = result[MSB]; Z = (result==0).
  - C = carry-out for ADD, and 1 when A>=B unsigned for SUB. C=0 for all other ops.
  - V = signed overflow for ADD/SUB, 0 otherwise.
- Arithmetic wraps modulo 2^WIDTH.
- destSel=0 is written like any other register; there is no hardwired zero.

Optional Feature:
- Macro ALU_EXEC_MUL_EN.
- Defined: MUL state and multiplier datapath are compiled in; behaviour as above.
- Undefined: no MUL state or accumulator logic. Opcode 1001 is treated as illegal: EXEC goes to WB, illegal=1, no write-back, 2-cycle latency.

Test Plan:
- Reset mid-MUL: assert rst 10 cycles into a MUL -> immediately busy=0, writeEnable=0, flags=0. The next ADD completes normally.
- ADD srcA=32'hFFFFFFFF, srcB=1, destSel=5 -> 2 cycles after start: writeEnable=1, regWriteSel=5, writeData=0, flags N=0 Z=1 C=1 V=0. The register file then reads 0 from r5.
- SUB 32'h80000000 - 1, destSel=31 -> writeData=32'h7FFFFFFF, V=1, C=1, N=0. Then SRA of 32'h80000000 by B=4 -> writeData=32'hF8000000.
- MUL 32'h0000FFF0 * 32'h00000010, destSel=16 (macro defined) -> done exactly 34 cycles after start, writeData=32'h000FFF00, busy high for 34 cycles.
- Same MUL with the macro undefined -> done after 2 cycles, illegal=1, writeEnable=0. Opcode 1111 gives the same response in both builds.
- Start held high continuously with 16 ADDs (destSel=i, srcA=32'hFFFF000F, srcB=i) -> one write per 3 cycles, no dropped or duplicated writes. Extra start pulses during busy are ignored.
